instr_fetch: RTL and testbench

Fetch stage of the RV32I core, directly upstream of `instr_mem`. Holds the program counter, drives the instruction memory address, and captures the returned word into an IF/ID register. The decode stage consumes that register through a valid/ready handshake. Supports fetch enable, stall via backpressure, and redirect/flush from branch/jump resolution.

---
 rtl/riscv_pkg.sv | 15 +
 rtl/instr_fetch.sv | 120 ++++++++++++
 tb/tb_instr_fetch.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: the canonical NOP, the fetch FSM state encoding
// and the sequential PC increment.
package riscv_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          PC_STEP   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// RV32I fetch stage: PC register, next-PC selection and IF/ID register with a valid/ready
// handshake to decode. Define FETCH_MISALIGN_CHECK_EN to trap on misaligned redirects.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    output logic [ADDR_WIDTH-1:0] instr_addr,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic                  misalign_fault
`endif
);

    fetch_state_t          state_reg, state_next;
    logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
    logic                  out_valid_reg, out_valid_next;
    logic [DATA_WIDTH-1:0] out_instr_reg, out_instr_next;
    logic [ADDR_WIDTH-1:0] out_pc_reg, out_pc_next;
    logic [ADDR_WIDTH-1:0] redirect_target;
    logic                  advance;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fault_reg, fault_next;
    logic misaligned;

    assign misaligned      = (redirect_pc[1:0] != 2'b00);
    assign redirect_target = redirect_pc;
`else
    // Without the trap, the low address bits are simply dropped on load.
    assign redirect_target = redirect_pc & ~ADDR_WIDTH'(PC_STEP - 1);
`endif

    assign advance = !out_valid_reg || out_ready;

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        out_valid_next = out_valid_reg;
        out_instr_next = out_instr_reg;
        out_pc_next    = out_pc_reg;
`ifdef FETCH_MISALIGN_CHECK_EN
        fault_next     = fault_reg;
`endif
        if (state_reg != TRAP && redirect_valid) begin
            // Redirect wins over capture; any entry accepted this cycle has already left.
            pc_next        = redirect_target;
            out_valid_next = 1'b0;
            out_instr_next = DATA_WIDTH'(NOP_INSTR);
            state_next     = (state_reg == RUN && fetch_en) ? RUN : IDLE;
`ifdef FETCH_MISALIGN_CHECK_EN
            if (misaligned) begin
                state_next = TRAP;
                fault_next = 1'b1;
            end
`endif
        end else if (state_reg == RUN) begin
            if (advance) begin
                out_instr_next = instr;
                out_pc_next    = pc_reg;
                out_valid_next = 1'b1;
                pc_next        = pc_reg + ADDR_WIDTH'(PC_STEP);
            end
            if (!fetch_en) begin
                state_next = IDLE;
            end
        end else if (state_reg == IDLE) begin
            // A leftover entry from RUN drains normally, but nothing new is captured.
            if (out_valid_reg && out_ready) begin
                out_valid_next = 1'b0;
            end
            if (fetch_en) begin
                state_next = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            pc_reg        <= RESET_PC;
            out_valid_reg <= 1'b0;
            out_instr_reg <= DATA_WIDTH'(NOP_INSTR);
            out_pc_reg    <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            fault_reg     <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            out_valid_reg <= out_valid_next;
            out_instr_reg <= out_instr_next;
            out_pc_reg    <= out_pc_next;
`ifdef FETCH_MISALIGN_CHECK_EN
            fault_reg     <= fault_next;
`endif
        end
    end

    assign instr_addr = pc_reg;
    assign out_valid  = out_valid_reg;
    assign out_instr  = out_instr_reg;
    assign out_pc     = out_pc_reg;
`ifdef FETCH_MISALIGN_CHECK_EN
    assign misalign_fault = fault_reg;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by a randomized run whose accepted
// entries are checked against an in-order stream of expected fetch addresses.
module tb_instr_fetch;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic [31:0] instr_addr;
    logic [31:0] instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalign_fault;
`endif

    logic [31:0] mem [64];
    logic [31:0] exp_q [$];
    logic [31:0] next_push;
    bit          sb_en = 1'b0;
    int          total = 0;
    int          bad = 0;
    int          xfer_cnt = 0;

    always #5 clk = ~clk;

    // Small memory that aliases every 256 bytes; combinational read.
    assign instr = mem[instr_addr[7:2]];

    instr_fetch #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_en      (fetch_en),
        .instr_addr    (instr_addr),
        .instr         (instr),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .misalign_fault(misalign_fault)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted entry must be the next word of the expected stream.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                xfer_cnt++;
                $display("xfer pc=%h instr=%h", out_pc, out_instr);
                if (sb_en) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_empty: got pc %h expected no transfer", out_pc);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_pc", out_pc, e);
                        check("sb_instr", out_instr, mem[e[7:2]]);
                    end
                end
            end
        end
    end

    initial begin
        int          cnt0;
        bit          redir;
        logic [31:0] tgt;

        rst = 1'b1; fetch_en = 1'b0; out_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h0010_0113;
        tick(); tick();
        rst = 1'b0;
        check("rst_valid", out_valid, 0);
        check("rst_addr", instr_addr, 32'h0);
        check("rst_instr", out_instr, NOP_INSTR);
        check("rst_pc", out_pc, 32'h0);

        // First instruction: RUN after one edge, capture on the next.
        fetch_en = 1'b1; out_ready = 1'b1;
        tick(); check("first_bubble", out_valid, 0);
        tick(); check("i0_valid", out_valid, 1); check("i0_pc", out_pc, 32'h0);
        check("i0_instr", out_instr, 32'h0050_0093);
        tick(); check("i1_pc", out_pc, 32'h4); check("i1_instr", out_instr, 32'h0010_0113);
        tick(); check("i2_pc", out_pc, 32'h8);

        // Backpressure holds everything.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", out_pc, 32'h8);
            check("stall_instr", out_instr, mem[2]);
            check("stall_addr", instr_addr, 32'hC);
        end
        out_ready = 1'b1;
        tick(); check("release_pc", out_pc, 32'hC); check("release_instr", out_instr, mem[3]);
        tick(); check("i4_pc", out_pc, 32'h10);
        out_ready = 1'b0;
        tick(); check("i4_hold", out_pc, 32'h10);

        // Redirect under stall flushes the held entry.
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick(); check("flush_valid", out_valid, 0); check("flush_instr", out_instr, NOP_INSTR);
        check("flush_addr", instr_addr, 32'h40);
        redirect_valid = 1'b0;
        tick(); check("tgt_valid", out_valid, 1); check("tgt_pc", out_pc, 32'h40);
        check("tgt_instr", out_instr, mem[16]);

        // Redirect with a same-cycle acceptance: that entry transfers exactly once.
        cnt0 = xfer_cnt;
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
        tick(); check("same_xfer", xfer_cnt - cnt0, 1); check("same_valid", out_valid, 0);
        redirect_valid = 1'b0; out_ready = 1'b0;
        tick(); check("same_tgt_pc", out_pc, 32'h80); check("same_tgt_valid", out_valid, 1);

        // PC wraps modulo 2^32.
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick(); redirect_valid = 1'b0;
        tick(); check("wrap_pc0", out_pc, 32'hFFFF_FFFC); check("wrap_instr0", out_instr, mem[63]);
        tick(); check("wrap_pc1", out_pc, 32'h0); check("wrap_instr1", out_instr, mem[0]);

        // Misaligned redirect.
        redirect_valid = 1'b1; redirect_pc = 32'h42;
        tick(); redirect_valid = 1'b0;
        check("mis_valid", out_valid, 0);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("mis_fault", misalign_fault, 1);
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("trap_valid", out_valid, 0);
            check("trap_fault", misalign_fault, 1);
            check("trap_addr", instr_addr, 32'h42);
        end
        redirect_valid = 1'b0;
        rst = 1'b1;
        tick(); rst = 1'b0;
        check("trap_rst_fault", misalign_fault, 0);
        tick();
`else
        check("mis_addr", instr_addr, 32'h40);
        tick(); check("mis_pc", out_pc, 32'h40); check("mis_resume", out_valid, 1);
        check("mis_next_addr", instr_addr, 32'h44);
`endif

        // Reset while an entry is live.
        out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h20;
        tick(); redirect_valid = 1'b0;
        tick(); check("pre_rst_valid", out_valid, 1); check("pre_rst_pc", out_pc, 32'h20);
        rst = 1'b1; fetch_en = 1'b0;
        tick(); rst = 1'b0;
        check("mid_rst_valid", out_valid, 0); check("mid_rst_addr", instr_addr, 32'h0);
        check("mid_rst_pc", out_pc, 32'h0); check("mid_rst_instr", out_instr, NOP_INSTR);
        tick(); check("idle_valid", out_valid, 0); check("idle_addr", instr_addr, 32'h0);

        // Randomized run: accepted entries form consecutive words from the last redirect.
        exp_q.delete();
        next_push = 32'h0;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(next_push);
            next_push += 32'd4;
        end
        sb_en = 1'b1;
        fetch_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            while (exp_q.size() < 8) begin
                exp_q.push_back(next_push);
                next_push += 32'd4;
            end
            if ($urandom_range(0, 19) == 0) fetch_en = !fetch_en;
            out_ready = ($urandom_range(0, 9) < 7);
            redir = ($urandom_range(0, 9) == 0);
`ifdef FETCH_MISALIGN_CHECK_EN
            tgt = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
`else
            tgt = 32'($urandom_range(0, 255));
`endif
            redirect_valid = redir;
            redirect_pc = tgt;
            tick();
            if (redir) begin
                exp_q.delete();
                next_push = {tgt[31:2], 2'b00};
            end
        end

        // Sustained throughput with decode always ready.
        redirect_valid = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
        while (exp_q.size() < 32) begin
            exp_q.push_back(next_push);
            next_push += 32'd4;
        end
        tick(); tick(); tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            check("throughput", out_valid, 1);
        end
        check("liveness", 32'(xfer_cnt > 300), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
